// File: rtl/ground_scroll_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ground_scroll_ctrl_if
// Brief    : Frame, button and collision inputs plus scroll state outputs of
//            the ground scroll controller.
// Revision : 1.0 - initial release
// ============================================================================
interface ground_scroll_ctrl_if;
  logic        fresh;
  logic        start_btn;
  logic        collision;
  logic        pause;
  logic        game_status;
  logic [3:0]  speed;
  logic [9:0]  ground_position;
  logic [15:0] score;
  logic        frame_tick;

  modport master (
    output fresh, start_btn, collision, pause,
    input  game_status, speed, ground_position, score, frame_tick
  );

  modport slave (
    input  fresh, start_btn, collision, pause,
    output game_status, speed, ground_position, score, frame_tick
  );
endinterface
`default_nettype wire

// File: rtl/ground_scroll_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ground_scroll_ctrl
// Brief    : IDLE/RUN/DEAD game flow, ground scroll position, speed ramp and
//            score. Define GROUND_PAUSE_EN to add the PAUSE state.
// Revision : 1.0 - initial release
// ============================================================================
module ground_scroll_ctrl #(
  parameter int GROUND_LEN  = 160,
  parameter int SPEED_INIT  = 6,
  parameter int SPEED_MAX   = 12,
  parameter int RAMP_FRAMES = 600,
  parameter int SCORE_DIV   = 6
) (
  input  wire logic            clk,
  input  wire logic            rst,
  ground_scroll_ctrl_if.slave  bus
);

  localparam int RAMP_W  = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
  localparam int SCORE_W = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;

  localparam logic [10:0]        c_ground_len = 11'(GROUND_LEN);
  localparam logic [3:0]         c_speed_init = 4'(SPEED_INIT);
  localparam logic [3:0]         c_speed_max  = 4'(SPEED_MAX);
  localparam logic [RAMP_W-1:0]  c_ramp_last  = RAMP_W'(RAMP_FRAMES - 1);
  localparam logic [SCORE_W-1:0] c_score_last = SCORE_W'(SCORE_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
`ifdef GROUND_PAUSE_EN
    ST_DEAD  = 2'd2,
    ST_PAUSE = 2'd3
`else
    ST_DEAD  = 2'd2
`endif
  } state_t;

  state_t               r_state;
  logic                 r_game_status;
  logic [3:0]           r_speed;
  logic [9:0]           r_pos;
  logic [15:0]          r_score;
  logic                 r_frame_tick;
  logic                 r_fresh_q;
  logic                 r_start_q;
  logic [RAMP_W-1:0]    r_ramp_cnt;
  logic [SCORE_W-1:0]   r_score_cnt;
`ifdef GROUND_PAUSE_EN
  logic                 r_pause_q;
  logic                 w_pause_rise;
`endif

  logic                 w_start_rise;
  logic [10:0]          w_pos_sum;
  logic [10:0]          w_pos_wrap;

  assign w_start_rise = bus.start_btn & ~r_start_q;
`ifdef GROUND_PAUSE_EN
  assign w_pause_rise = bus.pause & ~r_pause_q;
`endif

  // speed is always below the pattern period, so one conditional subtract wraps
  assign w_pos_sum  = {1'b0, r_pos} + {7'b0, r_speed};
  assign w_pos_wrap = (w_pos_sum >= c_ground_len) ? (w_pos_sum - c_ground_len) : w_pos_sum;

  assign bus.game_status     = r_game_status;
  assign bus.speed           = r_speed;
  assign bus.ground_position = r_pos;
  assign bus.score           = r_score;
  assign bus.frame_tick      = r_frame_tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_game_status <= 1'b0;
      r_speed       <= c_speed_init;
      r_pos         <= 10'd0;
      r_score       <= 16'd0;
      r_frame_tick  <= 1'b0;
      r_fresh_q     <= 1'b1;
      r_start_q     <= 1'b0;
      r_ramp_cnt    <= '0;
      r_score_cnt   <= '0;
`ifdef GROUND_PAUSE_EN
      r_pause_q     <= 1'b0;
`endif
    end else begin
      r_fresh_q    <= bus.fresh;
      r_frame_tick <= r_fresh_q & ~bus.fresh;
      r_start_q    <= bus.start_btn;
`ifdef GROUND_PAUSE_EN
      r_pause_q    <= bus.pause;
`endif

      case (r_state)
        ST_IDLE: begin
          if (bus.start_btn) begin
            r_state       <= ST_RUN;
            r_game_status <= 1'b1;
            r_speed       <= c_speed_init;
            r_score       <= 16'd0;
            r_ramp_cnt    <= '0;
            r_score_cnt   <= '0;
          end
        end

        ST_RUN: begin
          // collision beats a coincident frame tick: no advance, no score
          if (bus.collision) begin
            r_state       <= ST_DEAD;
            r_game_status <= 1'b0;
`ifdef GROUND_PAUSE_EN
          end else if (w_pause_rise) begin
            r_state       <= ST_PAUSE;
            r_game_status <= 1'b0;
`endif
          end else if (r_frame_tick) begin
            r_pos <= w_pos_wrap[9:0];

            if (r_ramp_cnt == c_ramp_last) begin
              r_ramp_cnt <= '0;
              if (r_speed != c_speed_max) begin
                r_speed <= r_speed + 4'd1;
              end
            end else begin
              r_ramp_cnt <= r_ramp_cnt + 1'b1;
            end

            if (r_score_cnt == c_score_last) begin
              r_score_cnt <= '0;
              if (r_score != 16'hFFFF) begin
                r_score <= r_score + 16'd1;
              end
            end else begin
              r_score_cnt <= r_score_cnt + 1'b1;
            end
          end
        end

        ST_DEAD: begin
          // position is intentionally kept so the ground resumes where it died
          if (w_start_rise) begin
            r_state       <= ST_RUN;
            r_game_status <= 1'b1;
            r_speed       <= c_speed_init;
            r_score       <= 16'd0;
            r_ramp_cnt    <= '0;
            r_score_cnt   <= '0;
          end
        end

`ifdef GROUND_PAUSE_EN
        ST_PAUSE: begin
          if (w_pause_rise) begin
            r_state       <= ST_RUN;
            r_game_status <= 1'b1;
          end
        end
`endif

        default: begin
          r_state       <= ST_IDLE;
          r_game_status <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ground_scroll_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ground_scroll_ctrl
// Brief    : Randomized self-checking bench for ground_scroll_ctrl against a
//            frame-count reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ground_scroll_ctrl;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DEAD  = 2;
  localparam int M_PAUSE = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ground_scroll_ctrl_if bus ();

  ground_scroll_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int tick_cnt = 0;

  // model: state, position and number of RUN frames since the last (re)start
  int m_state;
  int m_pos;
  int m_f;
  int m_ticks;

  logic [30:0] obs;
  logic [30:0] exp;

  always @(negedge clk) if (bus.frame_tick === 1'b1) tick_cnt++;

  function automatic int m_speed();
    int s;
    s = 6 + m_f / 600;
    return (s > 12) ? 12 : s;
  endfunction

  function automatic int m_score();
    int s;
    s = m_f / 6;
    return (s > 65535) ? 65535 : s;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    obs = {bus.game_status, bus.speed, bus.ground_position, bus.score};
    exp = {(m_state == M_RUN), 4'(m_speed()), 10'(m_pos), 16'(m_score())};
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    m_pos   = 0;
    m_f     = 0;
  endtask

  task automatic frame(input bit collide);
    bus.fresh = 1'b0;
    cyc(1);
    if (collide) bus.collision = 1'b1;
    cyc(1);
    bus.collision = 1'b0;
    bus.fresh = 1'b1;
    cyc($urandom_range(3, 1));
    m_ticks++;
    if (m_state == M_RUN) begin
      if (collide) m_state = M_DEAD;
      else begin
        m_pos = (m_pos + m_speed()) % 160;
        m_f++;
      end
    end
  endtask

  task automatic hit();
    bus.collision = 1'b1;
    cyc(1);
    bus.collision = 1'b0;
    cyc(1);
    if (m_state == M_RUN) m_state = M_DEAD;
  endtask

  task automatic press_start(input bit with_collision);
    bus.start_btn = 1'b1;
    if (with_collision) bus.collision = 1'b1;
    cyc(1);
    bus.start_btn = 1'b0;
    bus.collision = 1'b0;
    cyc(1);
    if (m_state == M_IDLE || m_state == M_DEAD) begin
      m_state = M_RUN;
      m_f = 0;
    end else if (m_state == M_RUN && with_collision) begin
      m_state = M_DEAD;
    end
  endtask

  task automatic pause_pulse();
    bus.pause = 1'b1;
    cyc(1);
    bus.pause = 1'b0;
    cyc(1);
`ifdef GROUND_PAUSE_EN
    if (m_state == M_RUN) m_state = M_PAUSE;
    else if (m_state == M_PAUSE) m_state = M_RUN;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    model_reset();
    tick_cnt = 0;
    m_ticks = 0;
    total++;
    if (bus.frame_tick !== 1'b0) begin
      bad++;
      $display("FAIL reset_tick: got %b want 0", bus.frame_tick);
    end
    for (int i = 0; i < 3; i++) frame(1'b0);
    snap();
    total++;
    if (obs !== exp || exp !== {1'b0, 4'd6, 10'd0, 16'd0}) begin
      bad++;
      $display("FAIL reset_idle: got %h want %h", obs, {1'b0, 4'd6, 10'd0, 16'd0});
    end
    total++;
    if (tick_cnt !== m_ticks) begin
      bad++;
      $display("FAIL reset_ticks: got %0d want %0d", tick_cnt, m_ticks);
    end
  endtask

  task automatic test_run30();
    press_start(1'b0);
    for (int i = 0; i < 30; i++) frame(1'b0);
    snap();
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL run30_model: got %h want %h", obs, exp);
    end
    total++;
    if (bus.ground_position !== 10'd20 || bus.score !== 16'd5 || bus.speed !== 4'd6) begin
      bad++;
      $display("FAIL run30_values: got pos=%0d score=%0d speed=%0d want 20 5 6",
               bus.ground_position, bus.score, bus.speed);
    end
    total++;
    if (tick_cnt !== m_ticks) begin
      bad++;
      $display("FAIL run30_ticks: got %0d want %0d", tick_cnt, m_ticks);
    end
  endtask

  task automatic test_ramp();
    int errs;
    errs = 0;
    while (m_f < 3700) begin
      frame(1'b0);
      snap();
      total++;
      if (obs !== exp) begin
        bad++;
        errs++;
        if (errs < 10) $display("FAIL ramp_frame%0d: got %h want %h", m_f, obs, exp);
      end
    end
    total++;
    if (bus.speed !== 4'd12) begin
      bad++;
      $display("FAIL ramp_ceiling: got %0d want 12", bus.speed);
    end
  endtask

  task automatic test_collide_on_tick();
    int      guard;
    logic [15:0] score_before;
    guard = 0;
    while (m_pos != 100 && guard < 80) begin
      frame(1'b0);
      guard++;
    end
    total++;
    if (m_pos != 100 || bus.ground_position !== 10'd100) begin
      bad++;
      $display("FAIL collide_reach100: got %0d want 100", bus.ground_position);
    end
    score_before = bus.score;
    frame(1'b1);
    snap();
    total++;
    if (obs !== exp || bus.score !== score_before) begin
      bad++;
      $display("FAIL collide_dead: got %h want %h", obs, exp);
    end
    for (int i = 0; i < 5; i++) frame(1'b0);
    snap();
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL dead_frozen: got %h want %h", obs, exp);
    end
    press_start(1'b1);
    snap();
    total++;
    if (obs !== exp || exp !== {1'b1, 4'd6, 10'd100, 16'd0}) begin
      bad++;
      $display("FAIL restart_wins: got %h want %h", obs, {1'b1, 4'd6, 10'd100, 16'd0});
    end
  endtask

  task automatic test_random();
    int op;
    int errs;
    errs = 0;
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(15, 0);
      if (op < 9) frame($urandom_range(11, 0) == 0);
      else if (op < 10) hit();
      else if (op < 13) press_start(1'b0);
      else if (op < 14) press_start(m_state == M_DEAD);
      else pause_pulse();
      snap();
      total++;
      if (obs !== exp) begin
        bad++;
        errs++;
        if (errs < 10) $display("FAIL random_step%0d: got %h want %h", i, obs, exp);
      end
    end
    total++;
    if (tick_cnt !== m_ticks) begin
      bad++;
      $display("FAIL random_ticks: got %0d want %0d", tick_cnt, m_ticks);
    end
  endtask

  task automatic test_pause();
    int p0;
    if (m_state == M_PAUSE) pause_pulse();
    if (m_state != M_RUN) press_start(1'b0);
    p0 = m_pos;
    pause_pulse();
    for (int i = 0; i < 10; i++) frame(1'b0);
    hit();
    snap();
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL pause_hold: got %h want %h", obs, exp);
    end
`ifdef GROUND_PAUSE_EN
    total++;
    if (bus.ground_position !== 10'(p0)) begin
      bad++;
      $display("FAIL pause_pos: got %0d want %0d", bus.ground_position, p0);
    end
`endif
    pause_pulse();
    for (int i = 0; i < 3; i++) frame(1'b0);
    snap();
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL pause_resume: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_mid_reset();
    int guard;
    if (m_state == M_PAUSE) pause_pulse();
    if (m_state != M_RUN) press_start(1'b0);
    guard = 0;
    while (m_speed() < 9 && guard < 2000) begin
      frame(1'b0);
      guard++;
    end
    snap();
    total++;
    if (obs !== exp || bus.speed !== 4'd9) begin
      bad++;
      $display("FAIL midrst_speed9: got %h want %h", obs, exp);
    end
    rst = 1'b1;
    cyc(1);
    model_reset();
    snap();
    total++;
    if (obs !== {1'b0, 4'd6, 10'd0, 16'd0} || obs !== exp) begin
      bad++;
      $display("FAIL midrst_values: got %h want %h", obs, {1'b0, 4'd6, 10'd0, 16'd0});
    end
    rst = 1'b0;
    cyc(1);
  endtask

  initial begin
    rst = 1'b1;
    bus.fresh = 1'b1;
    bus.start_btn = 1'b0;
    bus.collision = 1'b0;
    bus.pause = 1'b0;
    test_reset();
    test_run30();
    test_ramp();
    test_collide_on_tick();
    test_random();
    test_pause();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
